// File: rtl/breakthecode_pkg.sv
// Shared constants and types for the seven-segment scan driver.
//   NUM_DIGITS  : number of multiplexed digits
//   CN_DP_BIT   : cathode bit that drives the decimal point
//   CN_SEG_MSB  : top cathode bit of the g..a segment field
//   disp_cfg_t  : one complete display configuration (shadow/active copy)
//   hex_pattern : active-low g..a pattern for a hex nibble
package breakthecode_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CN_DP_BIT  = 7;
  localparam int CN_SEG_MSB = 6;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
  } disp_cfg_t;

  // Bit 0 = segment a ... bit 6 = segment g; 0 lights the segment.
  function automatic logic [6:0] hex_pattern(input logic [3:0] hex);
    case (hex)
      4'h0:    hex_pattern = 7'h40;
      4'h1:    hex_pattern = 7'h79;
      4'h2:    hex_pattern = 7'h24;
      4'h3:    hex_pattern = 7'h30;
      4'h4:    hex_pattern = 7'h19;
      4'h5:    hex_pattern = 7'h12;
      4'h6:    hex_pattern = 7'h02;
      4'h7:    hex_pattern = 7'h78;
      4'h8:    hex_pattern = 7'h00;
      4'h9:    hex_pattern = 7'h10;
      4'hA:    hex_pattern = 7'h08;
      4'hB:    hex_pattern = 7'h03;
      4'hC:    hex_pattern = 7'h46;
      4'hD:    hex_pattern = 7'h21;
      4'hE:    hex_pattern = 7'h06;
      default: hex_pattern = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder.
//   hex : 4-bit value to display
//   seg : active-low segments, seg[6:0] = g..a
module hex_to_seg7
  import breakthecode_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_pattern(hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver with double-buffered
// configuration and per-digit blinking.
//   clk        : single system clock
//   reset      : synchronous, active-low
//   digits     : eight hex nibbles, digits[4i+3:4i] is digit i
//   dp         : decimal-point request per digit (active-high)
//   digit_en   : digit i is shown only when bit i is set
//   blink_mask : digit i blinks when bit i is set
//   load       : one-cycle request to capture digits/dp/digit_en/blink_mask
//   load_ack   : one-cycle pulse when the captured values become active
//   frame_done : one-cycle pulse when the scan wraps from digit 7 to digit 0
//   AN         : anode select, active-low, one-hot-low or all high
//   CN         : cathodes, active-low, CN[7]=dp, CN[6:0]=g..a
//
// load/load_ack handshake: load is a fire-and-forget request (no ready);
// every cycle with load=1 overwrites the shadow copy. The shadow is promoted
// to the displayed copy only at a frame wrap, and load_ack marks exactly that
// promotion, so several loads within one frame yield a single load_ack.
module seg7_scan_driver
  import breakthecode_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 60
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              CN
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          pending;
  disp_cfg_t     shadow;
  disp_cfg_t     active;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    cur_hex;
  logic [6:0]    cur_seg;
  logic          shown;
  logic [7:0]    an_next;
  logic [7:0]    cn_next;

  assign slot_end = (presc == PRESC_LAST);
  assign wrap     = slot_end && (idx == 3'd7);
  assign cur_hex  = active.digits[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // Drive values for the digit selected by the current scan index; they are
  // registered below so AN/CN follow the index by exactly one cycle.
  always_comb begin
    shown   = active.en[idx] && !(blink_phase && active.blink[idx]);
    an_next = 8'hFF;
    cn_next = 8'hFF;
    if (shown) begin
      an_next[idx]                = 1'b0;
      cn_next[CN_DP_BIT]          = ~active.dp[idx];
      cn_next[CN_SEG_MSB:0]       = cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pending     <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
      AN          <= 8'hFF;
      CN          <= 8'hFF;
    end else begin
      AN         <= an_next;
      CN         <= cn_next;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;

      if (slot_end) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      // Frame boundary: promote the shadow only here so a frame is never
      // drawn with a mix of old and new configuration.
      if (wrap) begin
        frame_done <= 1'b1;
        if (pending) begin
          active   <= shadow;
          load_ack <= 1'b1;
        end
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      // A load on the wrap cycle lands in the shadow after the old shadow
      // was promoted, so it stays pending until the following wrap.
      if (load) begin
        shadow  <= '{digits: digits, dp: dp, en: digit_en, blink: blink_mask};
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits;
  logic [7:0]  dp, digit_en, blink_mask;
  logic        load;
  logic        load_ack, frame_done;
  logic [7:0]  AN, CN;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          k;
  logic [31:0] m_act_digits, m_sh_digits;
  logic [7:0]  m_act_dp, m_act_en, m_act_blink;
  logic [7:0]  m_sh_dp, m_sh_en, m_sh_blink;
  logic        m_pending;
  logic [7:0]  exp_an, exp_cn;
  logic        exp_ack, exp_fd;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dp         (dp),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .load       (load),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .AN         (AN),
    .CN         (CN)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  task automatic model_clear();
    k = 0;
    m_act_digits = '0; m_act_dp = '0; m_act_en = '0; m_act_blink = '0;
    m_sh_digits  = '0; m_sh_dp  = '0; m_sh_en  = '0; m_sh_blink  = '0;
    m_pending = 1'b0;
  endtask

  task automatic randomize_inputs();
    digits     = $urandom;
    dp         = 8'($urandom_range(0, 255));
    digit_en   = 8'($urandom_range(0, 255));
    blink_mask = 8'($urandom_range(0, 255));
  endtask

  // Driver: applies load for one edge and predicts what the outputs show
  // just after that edge. k counts clock edges since reset release; the
  // sample after edge k shows slot k/DIV of frame k/FRAME.
  task automatic tick(input logic ld);
    int  slot, i, ph;
    logic shown, wrap;
    load  = ld;
    slot  = k / DIV;
    i     = slot % 8;
    ph    = ((k / FRAME) / BF) % 2;
    shown = m_act_en[i] && !(ph == 1 && m_act_blink[i]);
    exp_an = shown ? ~(8'h01 << i) : 8'hFF;
    exp_cn = shown ? {~m_act_dp[i], seg_ref(m_act_digits[4*i +: 4])} : 8'hFF;
    wrap    = (k % FRAME) == FRAME - 1;
    exp_fd  = wrap;
    exp_ack = wrap && m_pending;
    if (wrap && m_pending) begin
      m_act_digits = m_sh_digits; m_act_dp = m_sh_dp;
      m_act_en = m_sh_en; m_act_blink = m_sh_blink;
    end
    if (ld) begin
      m_sh_digits = digits; m_sh_dp = dp; m_sh_en = digit_en; m_sh_blink = blink_mask;
      m_pending = 1'b1;
    end else if (wrap) begin
      m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    k++;
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      load = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset: got AN=%h CN=%h ack=%b fd=%b, expected AN=ff CN=ff ack=0 fd=0",
                 AN, CN, load_ack, frame_done);
      end
    end
    load  = 1'b0;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_idle();
    int fd_cnt = 0;
    for (int n = 0; n < 64; n++) begin
      randomize_inputs();
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL idle k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
      if (frame_done) fd_cnt++;
    end
    checks++;
    if (fd_cnt !== 2) begin
      errors++;
      $display("FAIL idle_frame_count: got %0d, expected 2", fd_cnt);
    end
  endtask

  task automatic test_load_basic();
    bit seen = 0;
    digits = 32'h76543210; digit_en = 8'hFF; dp = 8'h01; blink_mask = 8'h00;
    tick(1'b1);
    for (int n = 0; n < 40 && !seen; n++) begin
      randomize_inputs();
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL load_basic k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
      if (load_ack === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL load_basic_ack: got no load_ack within 40 cycles, expected one");
    end
    for (int n = 0; n < 29; n++) begin
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL load_basic_scan k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
      if (n == 0) begin
        checks++;
        if ({AN, CN} !== 16'hFE40) begin
          errors++;
          $display("FAIL digit0_slot: got AN=%h CN=%h, expected AN=fe CN=40", AN, CN);
        end
      end
      if (n == 28) begin
        checks++;
        if ({AN, CN} !== 16'h7FF8) begin
          errors++;
          $display("FAIL digit7_slot: got AN=%h CN=%h, expected AN=7f CN=f8", AN, CN);
        end
      end
    end
  endtask

  task automatic test_double_load();
    int acks = 0;
    int a4_bad = 0;
    bit after = 0;
    while (k % FRAME != 2) tick(1'b0);
    digits = 32'h11111111; digit_en = 8'hFF; dp = 8'h00; blink_mask = 8'h00;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    digits = 32'h22222222;
    tick(1'b1);
    for (int n = 0; n < 64; n++) begin
      randomize_inputs();
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL double_load k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
      if (after && CN !== 8'hA4) a4_bad++;
      if (load_ack === 1'b1) begin
        acks++;
        after = 1;
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL double_load_acks: got %0d, expected 1", acks);
    end
    checks++;
    if (a4_bad !== 0 || !after) begin
      errors++;
      $display("FAIL double_load_digits: got %0d samples not showing 2 (ack seen=%0d), expected 0", a4_bad, after);
    end
  endtask

  task automatic test_load_on_wrap();
    while (k % FRAME != FRAME - 1) tick(1'b0);
    digits = $urandom; digit_en = 8'hFF; dp = 8'($urandom_range(0, 255)); blink_mask = 8'h00;
    tick(1'b1);
    checks++;
    if ({load_ack, frame_done} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_load_first: got ack=%b fd=%b, expected ack=0 fd=1", load_ack, frame_done);
    end
    for (int n = 0; n < 32; n++) begin
      randomize_inputs();
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL wrap_load k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
    end
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL wrap_load_ack: got ack=%b 32 cycles after the wrap load, expected 1", load_ack);
    end
  endtask

  task automatic test_blink();
    bit seen = 0;
    int blank0 = 0;
    int blank_other = 0;
    digits = $urandom; digit_en = 8'hFF; dp = 8'($urandom_range(0, 255)); blink_mask = 8'h01;
    tick(1'b1);
    for (int n = 0; n < 40 && !seen; n++) begin
      tick(1'b0);
      if (load_ack === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL blink_ack: got no load_ack within 40 cycles, expected one");
    end
    for (int n = 0; n < 4 * FRAME; n++) begin
      randomize_inputs();
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL blink k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
      if (AN === 8'hFF) begin
        if (((k - 1) / DIV) % 8 == 0) blank0++;
        else blank_other++;
      end
    end
    checks++;
    if (blank0 !== 2 * DIV || blank_other !== 0) begin
      errors++;
      $display("FAIL blink_counts: got digit0 blank=%0d others blank=%0d, expected %0d and 0",
               blank0, blank_other, 2 * DIV);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    while (k % FRAME != 5) tick(1'b0);
    digits = $urandom; digit_en = 8'hFF; dp = 8'h00; blink_mask = 8'h00;
    tick(1'b1);
    tick(1'b0);
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid: got AN=%h CN=%h ack=%b fd=%b, expected AN=ff CN=ff ack=0 fd=0",
                 AN, CN, load_ack, frame_done);
      end
    end
    reset = 1'b1;
    model_clear();
    for (int n = 0; n < 40; n++) begin
      randomize_inputs();
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
      if (load_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_ack: got %0d acks, expected 0", acks);
    end
    // new load right at the restart proves the scan realigned to digit 0
    while (k % FRAME != 0) tick(1'b0);
    digits = 32'h76543210; digit_en = 8'hFF; dp = 8'h01; blink_mask = 8'h00;
    tick(1'b1);
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick(1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL reset_mid_scan k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      tick(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      checks++;
      if ({AN, CN, load_ack, frame_done} !== {exp_an, exp_cn, exp_ack, exp_fd}) begin
        errors++;
        $display("FAIL random k=%0d: got AN=%h CN=%h ack=%b fd=%b, expected AN=%h CN=%h ack=%b fd=%b",
                 k, AN, CN, load_ack, frame_done, exp_an, exp_cn, exp_ack, exp_fd);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    digits = '0; dp = '0; digit_en = '0; blink_mask = '0;
    model_clear();
    #1;
    test_reset();
    test_idle();
    test_load_basic();
    test_double_load();
    test_load_on_wrap();
    test_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 1000: clk cycles each digit is lit (1 kHz digit rate at 1 MHz clk).
REQ-002 Parameter BLINK_FRAMES, default 60: full frames per blink half-period.
REQ-003 clk  input  1  game-logic clock, 1 MHz nominal; the only clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 digits  input  32  eight 4-bit hex values; digits[4i+3:4i] is digit i.
REQ-006 dp  input  8  decimal-point request per digit, active-high.
REQ-007 digit_en  input  8  digit i shown only when bit i is 1.
REQ-008 blink_mask  input  8  digit i blinks when bit i is 1.
REQ-009 load  input  1  single-cycle request to capture digits/dp/digit_en/blink_mask.
REQ-010 load_ack  output  1  one-cycle pulse when captured values become active.
REQ-011 frame_done  output  1  one-cycle pulse at the end of digit 7's slot.
REQ-012 AN  output  8  anode select, active-low, one-hot-low or all high.
REQ-013 CN  output  8  cathodes, active-low; CN[7]=dp, CN[6:0]=segments g..a.

Function
REQ-014 A prescaler SHALL count 0..REFRESH_DIV-1; at terminal count the scan index (3 bits) SHALL advance i -> i+1, wrapping 7 -> 0.
REQ-015 While scan index = i, AN SHALL be ~(1<<i) if active digit_en[i]=1 and not blanked, else 8'hFF.
REQ-016 CN[6:0] SHALL be the active-low hex pattern (0-F) of active digit i; CN[7] SHALL be ~dp[i]; CN SHALL be 8'hFF whenever AN is 8'hFF.
REQ-017 AN/CN SHALL be registered; they change exactly one cycle after the scan index changes.
REQ-018 Inputs SHALL be captured into a shadow register on the cycle load=1; pending flag set.
REQ-019 Shadow SHALL transfer to active registers on the wrap 7 -> 0 only (no tearing mid-frame); load_ack pulses on that same cycle and pending clears.
REQ-020 A second load before the wrap SHALL overwrite the shadow; only one load_ack is issued.
REQ-021 load coincident with the wrap cycle SHALL be captured into shadow and applied at the following wrap.
REQ-022 frame_done SHALL pulse on the cycle the index wraps 7 -> 0.
REQ-023 A frame counter SHALL toggle blink_phase every BLINK_FRAMES frames; while blink_phase=1, digits with active blink_mask bit set SHALL be blanked.
REQ-024 Unknown/changing inputs when load=0 SHALL have no effect on outputs.

Reset
REQ-025 While reset=0 at a clk edge: AN=8'hFF, CN=8'hFF, load_ack=0, frame_done=0, prescaler=0, scan index=0, blink_phase=0, frame counter=0, pending=0, shadow and active registers=0 (all digits disabled).
REQ-026 Reset asserted mid-frame or with pending=1 SHALL discard the pending load without a load_ack.
REQ-027 First digit slot after reset release SHALL be digit 0 with full REFRESH_DIV length.

Structure
REQ-028 NUM_DIGITS=8, hex-to-segment patterns and the CN bit-order constants SHALL live in shared package breakthecode_pkg.
REQ-029 Combinational hex decoder SHALL be a sub-module hex_to_seg7 (4-bit in, 7-bit active-low out).
REQ-030 No other sub-modules; no clock dividers generating derived clocks (enable-based only).

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset low 3 cycles then release, no load -> AN=FF, CN=FF for 64 cycles, frame_done every 32 cycles.
REQ-032 load with digits=32'h76543210, digit_en=FF, dp=01 -> load_ack at next wrap; digit 0 slot AN=FE, CN=40 (dp lit, pattern '0' = 7'h40); digit 7 slot AN=7F, CN=F8.
REQ-033 Two loads (digits 1111_1111 then 2222_2222) within one frame -> one load_ack; displayed digits all '2' (CN=A4).
REQ-034 load on wrap cycle -> no ack at that wrap, ack at the next (32 cycles later).
REQ-035 blink_mask=01, digit_en=FF -> digit 0 AN=FF during frames 2-3, 6-7, ...; other digits unaffected.
REQ-036 Reset pulsed mid-frame with pending load -> AN=FF, no load_ack, scan restarts at digit 0.
